lfsr_prpg: RTL and testbench

LFSR_PRPG -- requirements
Module: lfsr_prpg

---
 rtl/lfsr_prpg.sv | 44 ++++
 tb/tb_lfsr_prpg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_prpg.sv
// lfsr_prpg: Fibonacci LFSR pattern generator with pattern index, wrap pulse and sticky lockup flag.
module lfsr_prpg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] SEED = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             valid,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             lockup
);
    // an all-zero seed would lock the register, so fall back to 1
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    logic             fb;
    logic [WIDTH-1:0] nxt;
    assign fb   = ^(q & TAPS);
    assign nxt  = {q[WIDTH-2:0], fb};
    assign sout = q[WIDTH-1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q      <= SEED_EFF;
            cnt    <= '0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b1;
            if (q == '0) begin
                q      <= SEED_EFF;
                cnt    <= '0;
                wrap   <= 1'b0;
                lockup <= 1'b1;
            end else begin
                q    <= nxt;
                cnt  <= (nxt == SEED_EFF) ? '0 : cnt + 1'b1;
                wrap <= (nxt == SEED_EFF);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_prpg.sv
// tb_lfsr_prpg: vector table, period/lockup/reset corner cases and randomized runs against a step model.
module tb_lfsr_prpg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] q, cnt;
    logic       sout, valid, wrap, lockup;
    logic [3:0] q4, cnt4;
    logic       sout4, valid4, wrap4, lockup4;
    int         total = 0;
    int         bad = 0;

    always #10 clk = ~clk;

    lfsr_prpg dut (
        .clk(clk), .reset(reset), .q(q), .sout(sout), .valid(valid),
        .cnt(cnt), .wrap(wrap), .lockup(lockup)
    );

    lfsr_prpg #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut4 (
        .clk(clk), .reset(reset), .q(q4), .sout(sout4), .valid(valid4),
        .cnt(cnt4), .wrap(wrap4), .lockup(lockup4)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] cnt;
    } vec_t;

    function automatic int adv(input int s, input int taps, input int w);
        return ((s << 1) | ($countones(s & taps) & 1)) & ((1 << w) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic chk8(input int s, input int k, input int lk);
        chk("q", q, s);
        chk("cnt", cnt, k % 255);
        chk("wrap", wrap, (k > 0 && k % 255 == 0) ? 1 : 0);
        chk("valid", valid, 1);
        chk("sout", sout, (s >> 7) & 1);
        chk("lockup", lockup, lk);
    endtask

    // call at posedge+2 so the low pulse (lo <= 15 ns) sits between edges
    task automatic rst_pulse(input int lo);
        reset = 1'b0;
        #1;
        chk("rst_q", q, 8'h01);
        chk("rst_cnt", cnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_lockup", lockup, 0);
        #(lo - 1);
        reset = 1'b1;
    endtask

    initial begin
        vec_t vecs[7];
        bit   seen[256];
        bit   seen4[16];
        int   s, k, lk, uniq, ones, s4, uniq4;
        vecs = '{'{8'h02, 8'd1}, '{8'h04, 8'd2}, '{8'h08, 8'd3}, '{8'h11, 8'd4},
                 '{8'h23, 8'd5}, '{8'h47, 8'd6}, '{8'h8E, 8'd7}};
        #1 reset = 1'b0;
        #4;
        chk("reset_q", q, 8'h01);
        chk("reset_cnt", cnt, 0);
        chk("reset_valid", valid, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_lockup", lockup, 0);
        chk("reset_sout", sout, 0);
        #5;
        chk("reset_hold_q", q, 8'h01);
        #6 reset = 1'b1;

        s = 1; k = 0; uniq = 0; ones = 0;
        for (int i = 0; i < 7; i++) begin
            step;
            chk("vec_q", q, vecs[i].q);
            chk("vec_cnt", cnt, vecs[i].cnt);
            chk("vec_valid", valid, 1);
            chk("vec_wrap", wrap, 0);
            s = adv(s, 'hB8, 8); k++;
            if (!seen[q]) uniq++;
            seen[q] = 1'b1;
            ones += int'(q[7]);
        end
        for (int i = 7; i < 255; i++) begin
            step;
            s = adv(s, 'hB8, 8); k++;
            chk8(s, k, 0);
            if (!seen[q]) uniq++;
            seen[q] = 1'b1;
            ones += int'(q[7]);
        end
        chk("period_q", q, 8'h01);
        chk("period_cnt", cnt, 0);
        chk("period_wrap", wrap, 1);
        chk("period_distinct", uniq, 255);
        chk("period_ones", ones, 128);
        step;
        chk("wrap_one_cycle", wrap, 0);
        chk("after_wrap_q", q, 8'h02);

        step; step;
        rst_pulse(10);
        step;
        chk("restart_q", q, 8'h02);
        chk("restart_cnt", cnt, 1);
        chk("restart_valid", valid, 1);

        dut.q = 8'h00;
        step;
        chk("lock_q", q, 8'h01);
        chk("lock_cnt", cnt, 0);
        chk("lock_flag", lockup, 1);
        step;
        chk("lock_sticky", lockup, 1);
        chk("lock_next_q", q, 8'h02);
        rst_pulse(12);

        s = 1; k = 0; lk = 0;
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(1, 300);
            for (int j = 0; j < n; j++) begin
                step;
                s = adv(s, 'hB8, 8); k++;
                chk8(s, k, lk);
            end
            if ($urandom_range(0, 3) == 0) begin
                dut.q = 8'h00;
                step;
                s = 1; k = 0; lk = 1;
                chk8(s, k, lk);
            end
            rst_pulse($urandom_range(2, 15));
            s = 1; k = 0; lk = 0;
        end

        s4 = 1; uniq4 = 0;
        for (int i = 1; i <= 30; i++) begin
            step;
            s4 = adv(s4, 'hC, 4);
            chk("w4_q", q4, s4);
            chk("w4_cnt", cnt4, i % 15);
            chk("w4_wrap", wrap4, (i % 15 == 0) ? 1 : 0);
            chk("w4_sout", sout4, (s4 >> 3) & 1);
            if (i <= 15) begin
                if (!seen4[q4]) uniq4++;
                seen4[q4] = 1'b1;
            end
        end
        chk("w4_distinct", uniq4, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
